// File: rtl/tartaruga_pkg.sv
// Shared types and encodings for the tartaruga RV32I pipeline.
package tartaruga_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef logic [XLEN-1:0]   bus32_t;
  typedef logic [REG_AW-1:0] reg_idx_t;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef struct packed {
    bus32_t   pc;
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    bus32_t   imm;
    alu_op_t  alu_op;
    logic     src_a_pc;
    logic     src_b_imm;
    logic     reg_we;
    logic     mem_read;
    logic     mem_write;
    logic     branch;
    logic     jump;
    logic     illegal;
    logic [2:0] funct3;
  } decoded_instr_t;

  // Immediate format implied by the major opcode.
  function automatic imm_type_t imm_type_of(input logic [6:0] opcode);
    imm_type_t t;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: t = IMM_I;
      OPC_STORE:                      t = IMM_S;
      OPC_BRANCH:                     t = IMM_B;
      OPC_LUI, OPC_AUIPC:             t = IMM_U;
      OPC_JAL:                        t = IMM_J;
      default:                        t = IMM_NONE;
    endcase
    return t;
  endfunction

  // Integer ALU op from funct3; alt selects SUB/SRA.
  function automatic alu_op_t alu_of_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction, sign-extended from instr[31].
module imm_gen
  import tartaruga_pkg::*;
(
  input  logic [31:0] instr,
  output bus32_t      imm
);

  imm_type_t imm_type;

  assign imm_type = imm_type_of(instr[6:0]);

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: control decoder feeding a one-entry ID register with valid/ready.
module decode
  import tartaruga_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        ready_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] pc_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [31:0] imm_o,
  output alu_op_t     alu_op_o,
  output logic        src_a_pc_o,
  output logic        src_b_imm_o,
  output logic        reg_we_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        branch_o,
  output logic        jump_o,
  output logic        illegal_o,
  output logic [2:0]  funct3_o
);

  decoded_instr_t d_q;
  decoded_instr_t d_c;
  logic           valid_q;
  logic           accept;
  logic           ill;
  bus32_t         imm_c;
  logic [6:0]     opcode;
  logic [2:0]     funct3;
  logic [6:0]     funct7;

  imm_gen u_imm_gen (
    .instr (instr_i),
    .imm   (imm_c)
  );

  assign opcode  = instr_i[6:0];
  assign funct3  = instr_i[14:12];
  assign funct7  = instr_i[31:25];
  assign ready_o = ~valid_q | ready_i;
  assign accept  = valid_i & ready_o & ~flush_i;

  // Control decoder; illegal encodings keep valid but drop every side effect.
  always_comb begin
    d_c        = '0;
    ill        = 1'b0;
    d_c.pc     = pc_i;
    d_c.rs1    = instr_i[19:15];
    d_c.rs2    = instr_i[24:20];
    d_c.rd     = instr_i[11:7];
    d_c.imm    = imm_c;
    d_c.funct3 = funct3;
    d_c.alu_op = ALU_ADD;
    case (opcode)
      OPC_LUI: begin
        d_c.alu_op    = ALU_PASS_B;
        d_c.src_b_imm = 1'b1;
        d_c.reg_we    = 1'b1;
      end
      OPC_AUIPC: begin
        d_c.src_a_pc  = 1'b1;
        d_c.src_b_imm = 1'b1;
        d_c.reg_we    = 1'b1;
      end
      OPC_JAL: begin
        d_c.src_a_pc  = 1'b1;
        d_c.src_b_imm = 1'b1;
        d_c.reg_we    = 1'b1;
        d_c.jump      = 1'b1;
      end
      OPC_JALR: begin
        d_c.src_b_imm = 1'b1;
        d_c.reg_we    = 1'b1;
        d_c.jump      = 1'b1;
        ill           = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        d_c.alu_op = ALU_SUB;
        d_c.branch = 1'b1;
        d_c.rd     = '0;
        ill        = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        d_c.src_b_imm = 1'b1;
        d_c.reg_we    = 1'b1;
        d_c.mem_read  = 1'b1;
        ill           = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        d_c.src_b_imm = 1'b1;
        d_c.mem_write = 1'b1;
        d_c.rd        = '0;
        ill           = (funct3 >= 3'b011);
      end
      OPC_OP_IMM: begin
        d_c.src_b_imm = 1'b1;
        d_c.reg_we    = 1'b1;
        d_c.alu_op    = alu_of_funct3(funct3, funct7[5] && (funct3 == 3'b101));
        if (funct3 == 3'b001)
          ill = (funct7 != FUNCT7_BASE);
        else if (funct3 == 3'b101)
          ill = (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
      end
      OPC_OP: begin
        d_c.reg_we = 1'b1;
        d_c.alu_op = alu_of_funct3(funct3, funct7[5]);
        ill        = !((funct7 == FUNCT7_BASE) ||
                       ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      d_c.illegal   = 1'b1;
      d_c.alu_op    = ALU_ADD;
      d_c.src_a_pc  = 1'b0;
      d_c.src_b_imm = 1'b0;
      d_c.reg_we    = 1'b0;
      d_c.mem_read  = 1'b0;
      d_c.mem_write = 1'b0;
      d_c.branch    = 1'b0;
      d_c.jump      = 1'b0;
    end
    if (d_c.rd == '0) d_c.reg_we = 1'b0;
  end

  // ID pipeline register; flush wins over accept and drain.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= 1'b0;
      d_q     <= '0;
    end else begin
      if (flush_i)       valid_q <= 1'b0;
      else if (accept)   valid_q <= 1'b1;
      else if (ready_i)  valid_q <= 1'b0;
      if (accept) d_q <= d_c;
    end
  end

  assign valid_o     = valid_q;
  assign pc_o        = d_q.pc;
  assign rs1_o       = d_q.rs1;
  assign rs2_o       = d_q.rs2;
  assign rd_o        = d_q.rd;
  assign imm_o       = d_q.imm;
  assign alu_op_o    = d_q.alu_op;
  assign src_a_pc_o  = d_q.src_a_pc;
  assign src_b_imm_o = d_q.src_b_imm;
  assign reg_we_o    = d_q.reg_we;
  assign mem_read_o  = d_q.mem_read;
  assign mem_write_o = d_q.mem_write;
  assign branch_o    = d_q.branch;
  assign jump_o      = d_q.jump;
  assign illegal_o   = d_q.illegal;
  assign funct3_o    = d_q.funct3;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for the decode stage: reference decoder, stalls, flush, illegal and reset.
module tb_decode;
  import tartaruga_pkg::*;

  logic        clk_i;
  logic        rstn_i;
  logic        flush_i;
  logic        valid_i;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        ready_o;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] pc_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [31:0] imm_o;
  alu_op_t     alu_op_o;
  logic        src_a_pc_o, src_b_imm_o, reg_we_o, mem_read_o, mem_write_o;
  logic        branch_o, jump_o, illegal_o;
  logic [2:0]  funct3_o;

  decoded_instr_t obs;
  decoded_instr_t exp_d;
  decoded_instr_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;

  decode dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .instr_i     (instr_i),
    .pc_i        (pc_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .pc_o        (pc_o),
    .rs1_o       (rs1_o),
    .rs2_o       (rs2_o),
    .rd_o        (rd_o),
    .imm_o       (imm_o),
    .alu_op_o    (alu_op_o),
    .src_a_pc_o  (src_a_pc_o),
    .src_b_imm_o (src_b_imm_o),
    .reg_we_o    (reg_we_o),
    .mem_read_o  (mem_read_o),
    .mem_write_o (mem_write_o),
    .branch_o    (branch_o),
    .jump_o      (jump_o),
    .illegal_o   (illegal_o),
    .funct3_o    (funct3_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always_comb begin
    obs           = '0;
    obs.pc        = pc_o;
    obs.rs1       = rs1_o;
    obs.rs2       = rs2_o;
    obs.rd        = rd_o;
    obs.imm       = imm_o;
    obs.alu_op    = alu_op_o;
    obs.src_a_pc  = src_a_pc_o;
    obs.src_b_imm = src_b_imm_o;
    obs.reg_we    = reg_we_o;
    obs.mem_read  = mem_read_o;
    obs.mem_write = mem_write_o;
    obs.branch    = branch_o;
    obs.jump      = jump_o;
    obs.illegal   = illegal_o;
    obs.funct3    = funct3_o;
  end

  // Reference decoder written from the ISA tables.
  function automatic decoded_instr_t model(input logic [31:0] in, input logic [31:0] pc);
    decoded_instr_t d;
    alu_op_t tab[8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    logic [2:0] f3 = in[14:12];
    logic [6:0] f7 = in[31:25];
    logic ill = 1'b0;
    logic [31:0] ii = {{20{in[31]}}, in[31:20]};
    d = '0;
    d.pc = pc; d.rs1 = in[19:15]; d.rs2 = in[24:20]; d.rd = in[11:7];
    d.funct3 = f3; d.alu_op = ALU_ADD;
    case (in[6:0])
      7'b0110111: begin d.imm = {in[31:12], 12'h0}; d.alu_op = ALU_PASS_B; d.src_b_imm = 1; d.reg_we = 1; end
      7'b0010111: begin d.imm = {in[31:12], 12'h0}; d.src_a_pc = 1; d.src_b_imm = 1; d.reg_we = 1; end
      7'b1101111: begin
        d.imm = {{12{in[31]}}, in[19:12], in[20], in[30:21], 1'b0};
        d.src_a_pc = 1; d.src_b_imm = 1; d.reg_we = 1; d.jump = 1;
      end
      7'b1100111: begin d.imm = ii; d.src_b_imm = 1; d.reg_we = 1; d.jump = 1; ill = (f3 != 0); end
      7'b1100011: begin
        d.imm = {{20{in[31]}}, in[7], in[30:25], in[11:8], 1'b0};
        d.alu_op = ALU_SUB; d.branch = 1; d.rd = 0; ill = (f3 == 2) || (f3 == 3);
      end
      7'b0000011: begin d.imm = ii; d.src_b_imm = 1; d.reg_we = 1; d.mem_read = 1; ill = (f3 == 3) || (f3 >= 6); end
      7'b0100011: begin
        d.imm = {{20{in[31]}}, in[31:25], in[11:7]};
        d.src_b_imm = 1; d.mem_write = 1; d.rd = 0; ill = (f3 >= 3);
      end
      7'b0010011: begin
        d.imm = ii; d.src_b_imm = 1; d.reg_we = 1; d.alu_op = tab[f3];
        if (f3 == 1) ill = (f7 != 0);
        if (f3 == 5) begin
          ill = !(f7 == 7'h00 || f7 == 7'h20);
          if (f7 == 7'h20) d.alu_op = ALU_SRA;
        end
      end
      7'b0110011: begin
        d.reg_we = 1; d.alu_op = tab[f3];
        if (f7 == 7'h20 && f3 == 0) d.alu_op = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 5) d.alu_op = ALU_SRA;
        else if (f7 != 0) ill = 1;
      end
      default: ill = 1;
    endcase
    if (ill) begin
      d.illegal = 1; d.alu_op = ALU_ADD; d.src_a_pc = 0; d.src_b_imm = 0;
      d.reg_we = 0; d.mem_read = 0; d.mem_write = 0; d.branch = 0; d.jump = 0;
    end
    if (d.rd == 0) d.reg_we = 0;
    return d;
  endfunction

  // Push on accept, drop a held entry that a flush discards.
  always @(posedge clk_i) begin
    if (rstn_i) begin
      if (flush_i && valid_o && !ready_i && sb_q.size() > 0) void'(sb_q.pop_front());
      if (valid_i && ready_o && !flush_i) sb_q.push_back(model(instr_i, pc_i));
    end
  end

  // Compare whenever execute takes an instruction.
  always @(negedge clk_i) begin
    if (rstn_i && valid_o && ready_i) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got %h, expected nothing", obs);
      end else begin
        exp_d = sb_q.pop_front();
        if (obs !== exp_d) begin
          n_err++;
          $display("FAIL sb_decode: got %h, expected %h", obs, exp_d);
        end
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    logic acc = 1'b0;
    valid_i = 1'b1; instr_i = ins; pc_i = pc;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk_i);
      acc = ready_o;
      @(posedge clk_i);
      #1;
    end
    valid_i = 1'b0;
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: instr %h not accepted in 20 cycles", ins);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk_i);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; flush_i = 1'b0; valid_i = 1'b1; ready_i = 1'b0;
    instr_i = 32'h00500093; pc_i = 32'h1234;
    repeat (3) @(posedge clk_i);
    #1;
    n_cmp++;
    if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, expected 0", valid_o); end
    n_cmp++;
    if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b, expected 1", ready_o); end
    n_cmp++;
    if (obs !== '0) begin n_err++; $display("FAIL reset_outputs: got %h, expected 0", obs); end
    valid_i = 1'b0; ready_i = 1'b1;
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_basic();
    ready_i = 1'b1;
    send(32'h00500093, 32'h100);
    n_cmp++;
    if ({valid_o, rd_o, rs1_o, imm_o, alu_op_o, src_b_imm_o, reg_we_o} !==
        {1'b1, 5'd1, 5'd0, 32'd5, ALU_ADD, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL addi_fields: got rd=%0d rs1=%0d imm=%h alu=%0d we=%b, expected rd=1 rs1=0 imm=5 alu=0 we=1",
               rd_o, rs1_o, imm_o, alu_op_o, reg_we_o);
    end
    send(32'h0020A423, 32'h104);
    n_cmp++;
    if ({rs1_o, rs2_o, imm_o, mem_write_o, reg_we_o, funct3_o} !==
        {5'd1, 5'd2, 32'd8, 1'b1, 1'b0, 3'b010}) begin
      n_err++;
      $display("FAIL sw_fields: got rs1=%0d rs2=%0d imm=%h mw=%b we=%b f3=%b, expected 1 2 8 1 0 010",
               rs1_o, rs2_o, imm_o, mem_write_o, reg_we_o, funct3_o);
    end
    send(32'hFE208EE3, 32'h108);
    n_cmp++;
    if ({branch_o, imm_o, alu_op_o, reg_we_o} !== {1'b1, 32'hFFFFFFFC, ALU_SUB, 1'b0}) begin
      n_err++;
      $display("FAIL beq_fields: got br=%b imm=%h alu=%0d we=%b, expected 1 fffffffc 1 0",
               branch_o, imm_o, alu_op_o, reg_we_o);
    end
    send(32'hABCDE2B7, 32'h10C);  // lui x5
    send(32'h00001317, 32'h110);  // auipc x6
    send(32'h800000EF, 32'h114);  // jal x1, negative offset
    send(32'h00428067, 32'h118);  // jalr x0, 4(x5)
    send(32'hFFC12183, 32'h11C);  // lw x3, -4(x2)
    send(32'h40315213, 32'h120);  // srai x4, x2, 3
    send(32'h40208233, 32'h124);  // sub x4, x1, x2
    send(32'h0020B2B3, 32'h128);  // sltu x5, x1, x2
    send(32'h00000013, 32'h12C);  // nop: rd=0
    drain();
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops[9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                           7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    time t0;
    ready_i = 1'b1;
    t0 = $time;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] r = $urandom;
      send({r[31:7], ops[$urandom_range(0, 8)]}, 32'h2000 + 32'(i * 4));
    end
    n_cmp++;
    if ($time - t0 != 400) begin
      n_err++;
      $display("FAIL back_to_back_rate: took %0t, expected 400", $time - t0);
    end
    drain();
  endtask

  task automatic test_stall();
    decoded_instr_t snap;
    ready_i = 1'b1;
    send(32'h00500093, 32'h300);
    ready_i = 1'b0;
    fork
      send(32'h0020A423, 32'h304);
      begin
        @(negedge clk_i);
        snap = obs;
        n_cmp++;
        if (ready_o !== 1'b0) begin n_err++; $display("FAIL stall_ready: got %b, expected 0", ready_o); end
        for (int i = 0; i < 3; i++) begin
          @(negedge clk_i);
          n_cmp++;
          if ({valid_o, ready_o} !== 2'b10 || obs !== snap) begin
            n_err++;
            $display("FAIL stall_hold: got v=%b r=%b %h, expected v=1 r=0 %h", valid_o, ready_o, obs, snap);
          end
        end
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_random_backpressure();
    bit done = 0;
    fork
      begin
        for (int i = 0; i < 30; i++) send($urandom, 32'h4000 + 32'(i * 4));
        done = 1;
      end
      while (!done) begin
        @(posedge clk_i);
        #1;
        ready_i = 1'($urandom_range(0, 1));
      end
    join
    ready_i = 1'b1;
    drain();
  endtask

  task automatic test_flush();
    ready_i = 1'b1;
    send(32'h00100113, 32'h500);
    valid_i = 1'b1; instr_i = 32'h00500093; pc_i = 32'h504; flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if ({valid_o, ready_o} !== 2'b01) begin
      n_err++;
      $display("FAIL flush_incoming: got v=%b r=%b, expected v=0 r=1", valid_o, ready_o);
    end
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    send(32'h00700193, 32'h508);
    valid_i = 1'b1; instr_i = 32'h0020A423; pc_i = 32'h50C; flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if ({valid_o, ready_o} !== 2'b01) begin
      n_err++;
      $display("FAIL flush_held: got v=%b r=%b, expected v=0 r=1", valid_o, ready_o);
    end
    @(posedge clk_i);
    #1;
    ready_i = 1'b1;
    send(32'h00900213, 32'h510);
    drain();
  endtask

  task automatic test_illegal();
    ready_i = 1'b1;
    send(32'hFFFFFFFF, 32'h600);
    n_cmp++;
    if ({valid_o, illegal_o, reg_we_o, mem_read_o, mem_write_o, branch_o, jump_o} !== 7'b1100000) begin
      n_err++;
      $display("FAIL illegal_ones: got v/ill/we/mr/mw/br/j=%b%b%b%b%b%b%b, expected 1100000",
               valid_o, illegal_o, reg_we_o, mem_read_o, mem_write_o, branch_o, jump_o);
    end
    send(32'h40001033, 32'h604);
    n_cmp++;
    if ({valid_o, illegal_o, reg_we_o, mem_read_o, mem_write_o, branch_o, jump_o} !== 7'b1100000) begin
      n_err++;
      $display("FAIL illegal_sll_alt: got v/ill/we/mr/mw/br/j=%b%b%b%b%b%b%b, expected 1100000",
               valid_o, illegal_o, reg_we_o, mem_read_o, mem_write_o, branch_o, jump_o);
    end
    send(32'h0000B183, 32'h608);  // load funct3 011
    send(32'h0020A063, 32'h60C);  // branch funct3 010
    send(32'h0020B023, 32'h610);  // store funct3 011
    send(32'h000090E7, 32'h614);  // jalr funct3 001
    send(32'h02209093, 32'h618);  // slli with funct7 0000001
    send(32'h0000007F, 32'h61C);  // unknown opcode
    drain();
  endtask

  task automatic test_idle_hold();
    decoded_instr_t snap;
    @(negedge clk_i);
    snap = obs;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i);
      #1;
      instr_i = $urandom; pc_i = $urandom;
      @(negedge clk_i);
      n_cmp++;
      if (obs !== snap || valid_o !== 1'b0) begin
        n_err++;
        $display("FAIL idle_hold: got v=%b %h, expected v=0 %h", valid_o, obs, snap);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset_mid_stall();
    ready_i = 1'b0;
    send(32'h00500093, 32'h700);
    #2;
    rstn_i = 1'b0;
    sb_q.delete();
    #1;
    n_cmp++;
    if ({valid_o, ready_o} !== 2'b01 || obs !== '0) begin
      n_err++;
      $display("FAIL reset_mid_stall: got v=%b r=%b %h, expected v=0 r=1 0", valid_o, ready_o, obs);
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    send(32'h00A00313, 32'h704);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_random_backpressure();
    test_flush();
    test_illegal();
    test_idle_hold();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded 500000 time units");
    $fatal(1, "timeout");
  end

endmodule
